rf_mp: RTL and testbench
========================

Name: rf_mp

Overview:
Parametrised multi-port integer register file for the npc core. It is the next generation of the single-cycle rf: configurable read and write port counts, write-to-read bypass, and a per-register busy scoreboard for multi-cycle loads. It also performs load-data alignment and sign/zero extension (lb/lbu/lh/lhu/lw) on a dedicated load write port. It sits between idu/exu (reads, ALU writeback) and the memory stage (load writeback).

Parameters:
XLEN, 32, register width in bits
NREG, 32, number of architectural registers (power of 2, ≥2)
NRD, 2, number of read ports
NWR, 2, number of write ports; port NWR-1 is the load port
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return the registered value only

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
rd_addr  in  NRD*AW  read addresses, AW=$clog2(NREG), port i at [AW*i +: AW]
rd_data  out  NRD*XLEN  read data, port i at [XLEN*i +: XLEN]
rd_busy  out  NRD  addressed register has a pending load
wr_en  in  NWR  write enables
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data; for the load port this is the raw aligned 32-bit memory word
ld_size  in  2  load port: 0=byte, 1=half, 2=word
ld_unsigned  in  1  load port: 1 = zero-extend, 0 = sign-extend
ld_off  in  2  load port: byte offset of the access inside the word
alloc_en  in  1  mark register alloc_addr busy (load issued)
alloc_addr  in  AW  register to mark busy
dbg_addr  in  AW  debug read address
dbg_data  out  XLEN  debug read data (never bypassed)

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0; all busy bits = 0. While in reset: rd_data = 0, rd_busy = 0, dbg_data = 0. Writes and allocs are ignored while rst=0 and on the first edge at which rst is still low.
- Register 0 is hardwired: writes to it are dropped, alloc to it is dropped, and reads of it return 0 with busy=0.
- Reads are combinational from storage.
  - BYPASS=1: if any wr_en[j] targets the read address in that cycle, the read returns the write data of the highest-index such port. Load-port data is returned after extension.
  - BYPASS=0: reads return the pre-edge stored value.
- Writes commit on the rising clk edge. If several ports write the same address in one cycle, the highest index wins.
- Load-port extension: the selected lane is wr_data >> (8*ld_off).
  - Byte: bits [7:0]. Half: bits [15:0], with ld_off[0] ignored (treated as 0).
  - Word: full word, ld_off ignored.
  - Extension uses ld_unsigned. ld_size=3 is treated as word.
- Scoreboard, one busy bit per register:
  - Set on an edge with alloc_en for alloc_addr.
  - Cleared on an edge where any wr_en port writes that register.
  - If alloc and a clearing write hit the same register in one cycle, alloc wins (busy stays 1 and the data is written).
  - Allocating an already-busy register keeps it busy.
- rd_busy[i] reflects the registered busy bit for rd_addr[i], not bypass-adjusted. A consumer stalls on it; the bypass makes the completing cycle's data visible, but busy drops only on the following cycle.
- Latency: write to read-visible = 0 cycles with BYPASS=1, 1 cycle with BYPASS=0. Alloc to busy visible = 1 cycle.

Decomposition:
- Shared package rf_pkg holds:
  - constants LD_B=2'd0, LD_H=2'd1, LD_W=2'd2
  - the function clog2_aw for AW
- Sub-module load_ext (purely combinational): inputs raw word, ld_size, ld_unsigned, ld_off; output extended XLEN value. It is instantiated once on the load port.
- Storage and the scoreboard stay in rf_mp using generate loops over ports.

Test Plan:
- Reset with rst=0 mid-run after writing x5=0x1234 -> x5 and dbg_data read 0 and all rd_busy=0 immediately, without waiting for a clock edge.
- wr port0 x1=0xDEADBEEF, rd_addr0=1 in the same cycle -> rd_data0=0xDEADBEEF with BYPASS=1 and 0 with BYPASS=0; both configs read 0xDEADBEEF next cycle. Write to x0 -> x0 still reads 0.
- Both ports write x3 (port0 0x11, port1 word 0x22) -> x3=0x22 next cycle.
- Load port, word 0x80F0_7F81:
  - byte, off=0, signed -> 0xFFFFFF81
  - byte, off=1, unsigned -> 0x0000007F
  - half, off=2, signed -> 0xFFFF80F0
  - word -> 0x80F07F81
- alloc x7 -> rd_busy=1 next cycle. Load-port write of x7 -> data bypassed that cycle, busy=0 the cycle after. Same-cycle alloc x7 plus write x7 -> busy stays 1 and the data is written.
- NRD=3, NWR=3 build: each port reads a distinct register concurrently; alloc x0 -> busy stays 0.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared load-size codes and address-width helper for the multi-port register file
package rf_pkg;
  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;

  function automatic int clog2_aw(input int n);
    int a;
    a = 0;
    while ((1 << a) < n) a++;
    return a;
  endfunction
endpackage

// File: rtl/rf_mp_load_ext.sv
// load_ext: selects the byte/half/word lane of a raw memory word and sign/zero extends it
module load_ext
  import rf_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     raw_i,
  input  logic [1:0]      ld_size_i,
  input  logic            ld_unsigned_i,
  input  logic [1:0]      ld_off_i,
  output logic [XLEN-1:0] ext_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // half accesses ignore the low offset bit; sizes other than byte/half behave as word
  always_comb begin
    byte_v = 8'(raw_i >> {ld_off_i, 3'b000});
    half_v = 16'(raw_i >> {ld_off_i[1], 4'b0000});
    ext_o  = ld_size_i == LD_B ? (ld_unsigned_i ? XLEN'(byte_v) : XLEN'($signed(byte_v))) :
             ld_size_i == LD_H ? (ld_unsigned_i ? XLEN'(half_v) : XLEN'($signed(half_v))) :
                                 (ld_unsigned_i ? XLEN'(raw_i)  : XLEN'($signed(raw_i)));
  end
endmodule

// File: rtl/rf_mp.sv
// rf_mp: multi-port register file with write-to-read bypass, load extension and busy scoreboard
module rf_mp
  import rf_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = clog2_aw(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [1:0]          ld_size,
  input  logic                ld_unsigned,
  input  logic [1:0]          ld_off,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] wd [NWR];
  logic [XLEN-1:0] ld_ext;

  load_ext #(.XLEN(XLEN)) u_ext (
    .raw_i        (wr_data[XLEN*(NWR-1) +: 32]),
    .ld_size_i    (ld_size),
    .ld_unsigned_i(ld_unsigned),
    .ld_off_i     (ld_off),
    .ext_o        (ld_ext)
  );

  for (genvar j = 0; j < NWR; j++) begin : g_wd
    if (j == NWR - 1) begin : g_ld
      assign wd[j] = ld_ext;
    end else begin : g_alu
      assign wd[j] = wr_data[XLEN*j +: XLEN];
    end
  end

  // later ports override earlier ones; alloc is applied after clears so it wins; x0 stays zero and idle
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        regs_d[wr_addr[AW*j +: AW]] = wd[j];
        busy_d[wr_addr[AW*j +: AW]] = 1'b0;
      end
    end
    if (alloc_en) busy_d[alloc_addr] = 1'b1;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // storage and scoreboard state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    assign a = rd_addr[AW*i +: AW];
    // stored value, optionally replaced by the highest-index same-cycle write to this address
    always_comb begin
      v = regs_q[a];
      if (BYPASS != 0)
        for (int j = 0; j < NWR; j++)
          if (wr_en[j] && wr_addr[AW*j +: AW] == a) v = wd[j];
    end
    assign rd_data[XLEN*i +: XLEN] = (rst && a != '0) ? v : '0;
    assign rd_busy[i] = rst && a != '0 && busy_q[a];
  end

  assign dbg_data = rst ? regs_q[dbg_addr] : '0;
endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: self-checking bench for rf_mp (bypass, no-bypass and 3x3 port builds)
module tb_rf_mp;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  rd_addr;
  logic [63:0] rd_data0, rd_data1;
  logic [1:0]  busy0, busy1;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  ld_size, ld_off;
  logic        ld_unsigned, alloc_en;
  logic [4:0]  alloc_addr, dbg_addr;
  logic [31:0] dbg0, dbg1;

  logic [14:0] r2_addr, w2_addr;
  logic [95:0] r2_data, w2_data;
  logic [2:0]  r2_busy, w2_en;
  logic        al2_en;
  logic [4:0]  al2_addr, dbg2_addr;
  logic [31:0] dbg2;

  rf_mp #(.BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ld_size(ld_size),
    .ld_unsigned(ld_unsigned), .ld_off(ld_off), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .dbg_addr(dbg_addr), .dbg_data(dbg0)
  );

  rf_mp #(.BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ld_size(ld_size),
    .ld_unsigned(ld_unsigned), .ld_off(ld_off), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .dbg_addr(dbg_addr), .dbg_data(dbg1)
  );

  rf_mp #(.NRD(3), .NWR(3)) u2 (
    .clk(clk), .rst(rst), .rd_addr(r2_addr), .rd_data(r2_data), .rd_busy(r2_busy),
    .wr_en(w2_en), .wr_addr(w2_addr), .wr_data(w2_data), .ld_size(ld_size),
    .ld_unsigned(ld_unsigned), .ld_off(ld_off), .alloc_en(al2_en),
    .alloc_addr(al2_addr), .dbg_addr(dbg2_addr), .dbg_data(dbg2)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [32];
  logic        busy_m [32];

  typedef struct {
    logic [31:0] raw;
    logic [1:0]  sz;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;
  ld_vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ext_m(input logic [31:0] raw, input logic [1:0] sz,
                                        input logic uns, input logic [1:0] off);
    logic [31:0] v;
    int o;
    if (sz == 2'd0) begin
      v = (raw >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      o = (int'(off) / 2) * 2;
      v = (raw >> (8 * o)) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else v = raw;
    return v;
  endfunction

  function automatic logic [31:0] wd_m(input int j);
    return j == 0 ? wr_data[31:0] : ext_m(wr_data[63:32], ld_size, ld_unsigned, ld_off);
  endfunction

  function automatic logic [31:0] rd_m(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = mem[a];
    if (byp)
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wr_addr[5*j +: 5] == a) v = wd_m(j);
    return v;
  endfunction

  task automatic settle();
    logic [4:0] a;
    #1;
    for (int i = 0; i < 2; i++) begin
      a = rd_addr[5*i +: 5];
      chk($sformatf("bypass rd%0d x%0d", i, a), rd_data0[32*i +: 32], rst ? rd_m(a, 1) : 32'd0);
      chk($sformatf("nobypass rd%0d x%0d", i, a), rd_data1[32*i +: 32], rst ? rd_m(a, 0) : 32'd0);
      chk($sformatf("busy rd%0d x%0d", i, a), 32'(busy0[i]), 32'(rst && a != 0 && busy_m[a]));
      chk($sformatf("nobypass busy rd%0d", i), 32'(busy1[i]), 32'(rst && a != 0 && busy_m[a]));
    end
    chk("dbg bypass build", dbg0, rst ? rd_m(dbg_addr, 0) : 32'd0);
    chk("dbg nobypass build", dbg1, rst ? rd_m(dbg_addr, 0) : 32'd0);
  endtask

  task automatic commit();
    logic [4:0] a;
    @(posedge clk);
    if (rst) begin
      for (int j = 0; j < 2; j++) begin
        a = wr_addr[5*j +: 5];
        if (wr_en[j]) begin
          if (a != 0) mem[a] = wd_m(j);
          busy_m[a] = 1'b0;
        end
      end
      if (alloc_en && alloc_addr != 0) busy_m[alloc_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = '0;
    alloc_en = 1'b0;
  endtask

  task automatic clear_model();
    for (int r = 0; r < 32; r++) begin
      mem[r] = '0;
      busy_m[r] = 1'b0;
    end
  endtask

  initial begin
    tbl[0] = '{32'h80F07F81, 2'd0, 1'b0, 2'd0, 32'hFFFFFF81};
    tbl[1] = '{32'h80F07F81, 2'd0, 1'b1, 2'd1, 32'h0000007F};
    tbl[2] = '{32'h80F07F81, 2'd1, 1'b0, 2'd2, 32'hFFFF80F0};
    tbl[3] = '{32'h80F07F81, 2'd2, 1'b0, 2'd0, 32'h80F07F81};
    tbl[4] = '{32'h80F07F81, 2'd0, 1'b0, 2'd3, 32'hFFFFFF80};
    tbl[5] = '{32'h80F07F81, 2'd1, 1'b1, 2'd1, 32'h00007F81};
    tbl[6] = '{32'h80F07F81, 2'd1, 1'b0, 2'd3, 32'hFFFF80F0};
    tbl[7] = '{32'h80F07F81, 2'd3, 1'b1, 2'd1, 32'h80F07F81};
    tbl[8] = '{32'h80F07F81, 2'd0, 1'b1, 2'd2, 32'h000000F0};

    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    ld_size = 2'd2; ld_off = '0; ld_unsigned = 1'b0;
    alloc_en = 1'b0; alloc_addr = '0; dbg_addr = '0;
    r2_addr = '0; w2_addr = '0; w2_data = '0; w2_en = '0;
    al2_en = 1'b0; al2_addr = '0; dbg2_addr = '0;
    clear_model();

    @(negedge clk);
    @(negedge clk);
    rd_addr = {5'd2, 5'd1};
    settle();
    chk("reset u2 data", r2_data[31:0], 32'd0);
    rst = 1'b1;

    wr_en = 2'b01; wr_addr = {5'd0, 5'd1}; wr_data = {32'd0, 32'hDEADBEEF};
    rd_addr = {5'd0, 5'd1};
    settle();
    chk("x1 same-cycle bypass", rd_data0[31:0], 32'hDEADBEEF);
    chk("x1 same-cycle nobypass", rd_data1[31:0], 32'd0);
    commit();
    idle();
    settle();
    chk("x1 next bypass", rd_data0[31:0], 32'hDEADBEEF);
    chk("x1 next nobypass", rd_data1[31:0], 32'hDEADBEEF);

    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'd0, 32'h55};
    rd_addr = {5'd0, 5'd0};
    settle();
    chk("x0 write bypass", rd_data0[31:0], 32'd0);
    commit();
    idle();
    dbg_addr = 5'd0;
    settle();
    chk("x0 after write", rd_data1[31:0], 32'd0);

    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h22, 32'h11}; ld_size = 2'd2;
    rd_addr = {5'd3, 5'd3};
    settle();
    chk("x3 dual bypass", rd_data0[31:0], 32'h22);
    commit();
    idle();
    settle();
    chk("x3 dual bypass build", rd_data0[31:0], 32'h22);
    chk("x3 dual nobypass build", rd_data1[31:0], 32'h22);

    for (int k = 0; k < 9; k++) begin
      wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {tbl[k].raw, 32'd0};
      ld_size = tbl[k].sz; ld_unsigned = tbl[k].uns; ld_off = tbl[k].off;
      rd_addr = {5'd0, 5'd9};
      settle();
      chk($sformatf("load vec%0d bypass", k), rd_data0[31:0], tbl[k].exp);
      commit();
      idle();
      dbg_addr = 5'd9;
      settle();
      chk($sformatf("load vec%0d stored", k), dbg1, tbl[k].exp);
    end

    ld_size = 2'd2; ld_unsigned = 1'b0; ld_off = 2'd0;
    alloc_en = 1'b1; alloc_addr = 5'd7; rd_addr = {5'd0, 5'd7};
    settle();
    chk("alloc x7 same cycle", 32'(busy0[0]), 32'd0);
    commit();
    idle();
    settle();
    chk("alloc x7 next cycle", 32'(busy0[0]), 32'd1);
    commit();
    wr_en = 2'b10; wr_addr = {5'd7, 5'd0}; wr_data = {32'h12345678, 32'd0};
    settle();
    chk("ld x7 bypass", rd_data0[31:0], 32'h12345678);
    chk("ld x7 busy held", 32'(busy0[0]), 32'd1);
    commit();
    idle();
    settle();
    chk("ld x7 busy cleared", 32'(busy0[0]), 32'd0);
    chk("ld x7 stored", rd_data1[31:0], 32'h12345678);
    commit();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'd0, 32'hCAFE};
    alloc_en = 1'b1; alloc_addr = 5'd7;
    settle();
    commit();
    idle();
    dbg_addr = 5'd7;
    settle();
    chk("alloc+write busy", 32'(busy0[0]), 32'd1);
    chk("alloc+write data", dbg0, 32'hCAFE);

    w2_en = 3'b111; w2_addr = {5'd12, 5'd11, 5'd10}; w2_data = {32'hC, 32'hB, 32'hA};
    al2_en = 1'b1; al2_addr = 5'd12;
    commit();
    w2_en = '0; al2_addr = 5'd0; r2_addr = {5'd12, 5'd11, 5'd10};
    #1;
    chk("3p rd0 x10", r2_data[31:0], 32'hA);
    chk("3p rd1 x11", r2_data[63:32], 32'hB);
    chk("3p rd2 x12", r2_data[95:64], 32'hC);
    chk("3p busy x12", 32'(r2_busy[2]), 32'd1);
    chk("3p busy x11", 32'(r2_busy[1]), 32'd0);
    commit();
    al2_en = 1'b0; r2_addr = {5'd12, 5'd11, 5'd0};
    #1;
    chk("3p alloc x0 busy", 32'(r2_busy[0]), 32'd0);
    chk("3p x12 still busy", 32'(r2_busy[2]), 32'd1);

    for (int n = 0; n < 300; n++) begin
      wr_en = 2'($urandom);
      wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data = {$urandom, $urandom};
      rd_addr = {5'($urandom_range(0, 7)), 5'(n % 5 == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7))};
      ld_size = 2'($urandom); ld_unsigned = 1'($urandom); ld_off = 2'($urandom);
      alloc_en = ($urandom % 4) == 0; alloc_addr = 5'($urandom_range(0, 7));
      dbg_addr = 5'($urandom_range(0, 7));
      settle();
      commit();
    end

    idle();
    ld_size = 2'd2;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'h1234};
    alloc_en = 1'b1; alloc_addr = 5'd5;
    settle();
    commit();
    idle();
    rd_addr = {5'd0, 5'd5}; dbg_addr = 5'd5;
    settle();
    chk("x5 before reset", rd_data1[31:0], 32'h1234);
    chk("x5 busy before reset", 32'(busy0[0]), 32'd1);
    wr_en = 2'b01; wr_data = {32'd0, 32'hFFFF};
    #2 rst = 1'b0;
    #1;
    chk("reset x5 bypass build", rd_data0[31:0], 32'd0);
    chk("reset x5 nobypass build", rd_data1[31:0], 32'd0);
    chk("reset dbg", dbg0, 32'd0);
    chk("reset busy", 32'(busy0), 32'd0);
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle();
    settle();
    chk("x5 after reset", dbg1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
